pipeline_stage_regs: RTL and testbench
======================================

Name: pipeline_stage_regs

Overview:
- Consumer side of the hazard stall/flush interface. Holds the PC register, the IF/ID register and the ID/EX register of the 5-stage MIPS pipeline.
- Applies stall_f, stall_d and flush_e from the hazard unit, plus the decode-stage branch redirect.
- Keeps saturating stall and flush event counters and a sticky interface-consistency error flag for debug.

Parameters:
- DATA_W, 32, width of PC, instruction and operand datapaths
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- stall_f  input  1  hold PC register
- stall_d  input  1  hold IF/ID register
- flush_e  input  1  insert bubble into ID/EX register
- pc_src_d  input  1  branch taken in decode; redirect PC and flush IF/ID
- pc_branch_d  input  DATA_W  branch target
- instr_f  input  DATA_W  fetched instruction
- reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d  input  1 each  decode control
- alu_ctrl_d  input  3  ALU control
- rd1_d, rd2_d, sign_imm_d  input  DATA_W each  decode operands
- rs_d, rt_d, rd_d  input  5 each  register specifiers
- pc_f  output  DATA_W  fetch PC
- instr_d, pc_plus4_d  output  DATA_W each  IF/ID contents
- valid_d  output  1  IF/ID holds a real instruction
- reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e  output  1 each  ID/EX control
- alu_ctrl_e  output  3; rd1_e, rd2_e, sign_imm_e  output  DATA_W each; rs_e, rt_e, rd_e  output  5 each
- valid_e  output  1  ID/EX holds a real instruction
- stall_cnt, flush_cnt  output  CNT_W each  event counters
- hz_err  output  1  sticky: stall_f and stall_d disagreed

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc_f=RESET_PC.
  - All IF/ID and ID/EX outputs 0; valid_d=0, valid_e=0.
  - stall_cnt=0, flush_cnt=0, hz_err=0.
  - Reset asserted mid-stall or mid-flush takes effect on that edge. The first post-reset edge behaves normally.
- PC register:
  - stall_f=1: hold.
  - Else pc_src_d=1: load pc_branch_d.
  - Else: load pc_f+4, modulo 2^DATA_W, so 0xFFFF_FFFC wraps to 0.
  - stall_f beats pc_src_d, because a branch stall means the branch operands are not yet valid.
- IF/ID register, priority stall_d > pc_src_d > load:
  - stall_d=1: hold all fields including valid_d.
  - Else pc_src_d=1: clear instr_d and pc_plus4_d to 0, valid_d=0.
  - Else: instr_d=instr_f, pc_plus4_d=pc_f+4, valid_d=1.
- ID/EX register, never stalled:
  - flush_e=1: all control outputs, data fields and specifiers become 0, valid_e=0. This is a bubble.
  - Else: load all _d inputs; valid_e=valid_d.
  - flush_e overrides pc_src_d effects on E.
- Latency: one cycle per stage. An instruction on instr_f appears on instr_d after 1 edge. Its decode fields appear on the _e outputs 1 edge after that, unless stalled or flushed.
- stall_cnt: +1 on each edge where stall_f=1. Saturates at 2^CNT_W-1 and never wraps.
- flush_cnt: +1 on each edge where pc_src_d=1 and stall_d=0, i.e. a taken IF/ID flush. Saturates at 2^CNT_W-1.
- hz_err: set on any edge where stall_f != stall_d. Cleared only by rst.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then 3 free cycles with RESET_PC=0, no stalls -> pc_f=0,4,8,12; instr_d follows instr_f one cycle later; valid_d=1 from cycle 2; stall_cnt=0.
- Load-use stall: stall_f=stall_d=flush_e=1 for 1 cycle with pc_f=0x10 -> pc_f stays 0x10; instr_d held; valid_e=0 and reg_write_e=0 next cycle; stall_cnt=1, then resumes at 0x14.
- Taken branch: pc_src_d=1, pc_branch_d=0x40 at pc_f=0x20 -> pc_f=0x40; instr_d=0 and valid_d=0 next cycle; flush_cnt=1.
- Simultaneous branch stall: stall_f=stall_d=1 and pc_src_d=1 -> PC and IF/ID hold; flush_cnt unchanged. Next cycle stall=0, pc_src_d=1 -> redirect, flush_cnt=1.
- Saturation with CNT_W=4: stall_f held 20 cycles -> stall_cnt reaches 15 and stays at 15. PC wrap from 0xFFFF_FFFC -> 0.
- Protocol error and reset mid-stall: stall_f=1, stall_d=0 for 1 cycle -> hz_err=1 and stays set; rst=1 during a stall -> next cycle pc_f=RESET_PC, counters 0, hz_err=0.

Source files
------------

// File: rtl/pipeline_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, consuming the
// hazard unit's stall/flush controls, plus saturating event counters and a sticky consistency flag.
module pipeline_stage_regs #(
  parameter int               DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_e,
  input  logic              pc_src_d,
  input  logic [DATA_W-1:0] pc_branch_d,
  input  logic [DATA_W-1:0] instr_f,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic              reg_dst_d,
  input  logic [2:0]        alu_ctrl_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] sign_imm_d,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [4:0]        rd_d,
  output logic [DATA_W-1:0] pc_f,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic              reg_write_e,
  output logic              mem_to_reg_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic              reg_dst_e,
  output logic [2:0]        alu_ctrl_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] sign_imm_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        rd_e,
  output logic              valid_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              hz_err
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus4;
    logic              valid;
  } ifid_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sign_imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              valid;
  } idex_t;

  logic [DATA_W-1:0] pc_q, pc_d, pc_plus4;
  ifid_t             ifid_q, ifid_d;
  idex_t             idex_q, idex_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hz_err_q, hz_err_d;

  assign pc_plus4 = pc_q + DATA_W'(4);

  always_comb begin
    // stall_f wins over a redirect: a stalled branch has stale operands
    pc_d = pc_q;
    if (!stall_f) pc_d = pc_src_d ? pc_branch_d : pc_plus4;

    ifid_d = ifid_q;
    if (!stall_d) begin
      if (pc_src_d) ifid_d = '0;
      else begin
        ifid_d.instr    = instr_f;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
      end
    end

    idex_d = '0;
    if (!flush_e) begin
      idex_d.reg_write  = reg_write_d;
      idex_d.mem_to_reg = mem_to_reg_d;
      idex_d.mem_write  = mem_write_d;
      idex_d.alu_src    = alu_src_d;
      idex_d.reg_dst    = reg_dst_d;
      idex_d.alu_ctrl   = alu_ctrl_d;
      idex_d.rd1        = rd1_d;
      idex_d.rd2        = rd2_d;
      idex_d.sign_imm   = sign_imm_d;
      idex_d.rs         = rs_d;
      idex_d.rt         = rt_d;
      idex_d.rd         = rd_d;
      idex_d.valid      = ifid_q.valid;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (pc_src_d && !stall_d && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);

    hz_err_d = hz_err_q | (stall_f ^ stall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ifid_q      <= '0;
      idex_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      hz_err_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      hz_err_q    <= hz_err_d;
    end
  end

  assign pc_f         = pc_q;
  assign instr_d      = ifid_q.instr;
  assign pc_plus4_d   = ifid_q.pc_plus4;
  assign valid_d      = ifid_q.valid;
  assign reg_write_e  = idex_q.reg_write;
  assign mem_to_reg_e = idex_q.mem_to_reg;
  assign mem_write_e  = idex_q.mem_write;
  assign alu_src_e    = idex_q.alu_src;
  assign reg_dst_e    = idex_q.reg_dst;
  assign alu_ctrl_e   = idex_q.alu_ctrl;
  assign rd1_e        = idex_q.rd1;
  assign rd2_e        = idex_q.rd2;
  assign sign_imm_e   = idex_q.sign_imm;
  assign rs_e         = idex_q.rs;
  assign rt_e         = idex_q.rt;
  assign rd_e         = idex_q.rd;
  assign valid_e      = idex_q.valid;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign hz_err       = hz_err_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs: free run, load-use stall, branch flush,
// branch stall, counter saturation (CNT_W=4), PC wrap, hz_err and reset mid-stall.
module tb_pipeline_stage_regs;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_f, stall_d, flush_e, pc_src_d;
  logic [DATA_W-1:0] pc_branch_d, instr_f;
  logic              reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
  logic [2:0]        alu_ctrl_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, sign_imm_d;
  logic [4:0]        rs_d, rt_d, rd_d;
  logic [DATA_W-1:0] pc_f, instr_d, pc_plus4_d;
  logic              valid_d;
  logic              reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
  logic [2:0]        alu_ctrl_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, sign_imm_e;
  logic [4:0]        rs_e, rt_e, rd_e;
  logic              valid_e;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              hz_err;

  int checks = 0;
  int errors = 0;

  pipeline_stage_regs #(.DATA_W(DATA_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d), .instr_f(instr_f),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .alu_ctrl_d(alu_ctrl_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e), .alu_ctrl_e(alu_ctrl_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .valid_e(valid_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hz_err(hz_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_f = 1'b1; stall_d = 1'b0; flush_e = 1'b0; pc_src_d = 1'b1;
    pc_branch_d = 32'hDEAD_BEEC; instr_f = 32'h1234_5678;
    reg_write_d = 1'b1; mem_to_reg_d = 1'b1; mem_write_d = 1'b1; alu_src_d = 1'b1; reg_dst_d = 1'b1;
    alu_ctrl_d = 3'b101; rd1_d = 32'h11; rd2_d = 32'h22; sign_imm_d = 32'h33;
    rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd3;
    tick(); tick();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_f, 32'h0); end
    checks++; if ({instr_d, pc_plus4_d, valid_d} !== '0) begin errors++; $display("FAIL reset_ifid: got %h %h %b exp 0", instr_d, pc_plus4_d, valid_d); end
    checks++; if ({reg_write_e, rd1_e, rd_e, alu_ctrl_e, valid_e} !== '0) begin errors++; $display("FAIL reset_idex: got rw=%b rd1=%h rd=%0d alu=%0d v=%b exp 0", reg_write_e, rd1_e, rd_e, alu_ctrl_e, valid_e); end
    checks++; if ({stall_cnt, flush_cnt, hz_err} !== '0) begin errors++; $display("FAIL reset_dbg: got %0d %0d %b exp 0 0 0", stall_cnt, flush_cnt, hz_err); end
    rst = 1'b0; stall_f = 1'b0; pc_src_d = 1'b0;
  endtask

  task automatic test_free_run();
    instr_f = 32'hA000_0000;
    tick();
    checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL free_pc0: got %h exp %h", pc_f, 32'h4); end
    checks++; if (instr_d !== 32'hA000_0000 || pc_plus4_d !== 32'h4 || valid_d !== 1'b1) begin errors++; $display("FAIL free_ifid0: got %h %h %b exp a0000000 4 1", instr_d, pc_plus4_d, valid_d); end
    checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL free_valid_e0: got %b exp 0", valid_e); end
    for (int i = 1; i <= 3; i++) begin
      instr_f = 32'hA000_0000 + i;
      tick();
      checks++; if (pc_f !== 32'(4 * (i + 1)) || instr_d !== 32'hA000_0000 + i || pc_plus4_d !== 32'(4 * (i + 1))) begin
        errors++; $display("FAIL free_step%0d: got pc=%h instr=%h pc4=%h", i, pc_f, instr_d, pc_plus4_d);
      end
    end
    checks++; if (valid_e !== 1'b1 || rd1_e !== 32'h11 || alu_ctrl_e !== 3'b101 || rd_e !== 5'd3) begin errors++; $display("FAIL free_idex: got v=%b rd1=%h alu=%0d rd=%0d exp 1 11 5 3", valid_e, rd1_e, alu_ctrl_e, rd_e); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL free_stall_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    instr_f = 32'hB000_0000;
    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    tick();
    checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL lu_pc_hold: got %h exp 10", pc_f); end
    checks++; if (instr_d !== 32'hA000_0003 || valid_d !== 1'b1) begin errors++; $display("FAIL lu_ifid_hold: got %h %b exp a0000003 1", instr_d, valid_d); end
    checks++; if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || rd1_e !== 32'h0 || rs_e !== 5'd0) begin errors++; $display("FAIL lu_bubble: got v=%b rw=%b rd1=%h rs=%0d exp 0", valid_e, reg_write_e, rd1_e, rs_e); end
    checks++; if (stall_cnt !== 4'd1 || hz_err !== 1'b0) begin errors++; $display("FAIL lu_cnt: got %0d %b exp 1 0", stall_cnt, hz_err); end
    stall_f = 1'b0; stall_d = 1'b0; flush_e = 1'b0;
    tick();
    checks++; if (pc_f !== 32'h14 || instr_d !== 32'hB000_0000 || pc_plus4_d !== 32'h14) begin errors++; $display("FAIL lu_resume: got %h %h %h exp 14 b0000000 14", pc_f, instr_d, pc_plus4_d); end
    checks++; if (valid_e !== 1'b1 || reg_write_e !== 1'b1 || rd2_e !== 32'h22) begin errors++; $display("FAIL lu_idex_resume: got %b %b %h exp 1 1 22", valid_e, reg_write_e, rd2_e); end
  endtask

  task automatic test_branch();
    tick(); tick(); tick();
    checks++; if (pc_f !== 32'h20) begin errors++; $display("FAIL br_setup: got %h exp 20", pc_f); end
    pc_src_d = 1'b1; pc_branch_d = 32'h40; flush_e = 1'b1;
    tick();
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL br_pc: got %h exp 40", pc_f); end
    checks++; if (instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || valid_d !== 1'b0) begin errors++; $display("FAIL br_ifid_flush: got %h %h %b exp 0", instr_d, pc_plus4_d, valid_d); end
    checks++; if (flush_cnt !== 4'd1 || valid_e !== 1'b0 || mem_write_e !== 1'b0) begin errors++; $display("FAIL br_cnt_e: got fc=%0d ve=%b mw=%b exp 1 0 0", flush_cnt, valid_e, mem_write_e); end
    pc_src_d = 1'b0; flush_e = 1'b0;
    tick();
    checks++; if (pc_f !== 32'h44 || valid_d !== 1'b1 || valid_e !== 1'b0 || reg_write_e !== 1'b1) begin errors++; $display("FAIL br_after: got pc=%h vd=%b ve=%b rw=%b exp 44 1 0 1", pc_f, valid_d, valid_e, reg_write_e); end
  endtask

  task automatic test_branch_stall();
    stall_f = 1'b1; stall_d = 1'b1; pc_src_d = 1'b1; pc_branch_d = 32'h80; instr_f = 32'hC000_0000;
    tick();
    checks++; if (pc_f !== 32'h44 || instr_d !== 32'hB000_0000 || valid_d !== 1'b1) begin errors++; $display("FAIL bs_hold: got %h %h %b exp 44 b0000000 1", pc_f, instr_d, valid_d); end
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin errors++; $display("FAIL bs_cnt: got fc=%0d sc=%0d exp 1 2", flush_cnt, stall_cnt); end
    stall_f = 1'b0; stall_d = 1'b0;
    tick();
    checks++; if (pc_f !== 32'h80 || valid_d !== 1'b0 || instr_d !== 32'h0 || flush_cnt !== 4'd2) begin errors++; $display("FAIL bs_redirect: got pc=%h vd=%b i=%h fc=%0d exp 80 0 0 2", pc_f, valid_d, instr_d, flush_cnt); end
    pc_src_d = 1'b0;
  endtask

  task automatic test_saturation();
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 13) begin
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d exp 15", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 4'd15 || pc_f !== 32'h80) begin errors++; $display("FAIL sat_hold: got sc=%0d pc=%h exp 15 80", stall_cnt, pc_f); end
    stall_f = 1'b0; stall_d = 1'b0; pc_src_d = 1'b1; pc_branch_d = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc_f !== 32'hFFFF_FFFC || flush_cnt !== 4'd3) begin errors++; $display("FAIL wrap_setup: got %h %0d exp fffffffc 3", pc_f, flush_cnt); end
    pc_src_d = 1'b0; instr_f = 32'hD000_0000;
    tick();
    checks++; if (pc_f !== 32'h0 || instr_d !== 32'hD000_0000 || pc_plus4_d !== 32'h0 || valid_d !== 1'b1) begin errors++; $display("FAIL wrap: got pc=%h i=%h pc4=%h vd=%b exp 0 d0000000 0 1", pc_f, instr_d, pc_plus4_d, valid_d); end
  endtask

  task automatic test_hz_err_reset();
    stall_f = 1'b1; stall_d = 1'b0;
    tick();
    checks++; if (hz_err !== 1'b1 || stall_cnt !== 4'd15) begin errors++; $display("FAIL hz_set: got %b %0d exp 1 15", hz_err, stall_cnt); end
    stall_f = 1'b0;
    tick();
    checks++; if (hz_err !== 1'b1) begin errors++; $display("FAIL hz_sticky: got %b exp 1", hz_err); end
    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1; pc_src_d = 1'b1; rst = 1'b1;
    tick();
    checks++; if (pc_f !== 32'h0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || hz_err !== 1'b0) begin errors++; $display("FAIL rst_mid: got pc=%h sc=%0d fc=%0d hz=%b exp 0 0 0 0", pc_f, stall_cnt, flush_cnt, hz_err); end
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || valid_e !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got %b %h %b exp 0 0 0", valid_d, instr_d, valid_e); end
    rst = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_e = 1'b0; pc_src_d = 1'b0; instr_f = 32'hE000_0000;
    tick();
    checks++; if (pc_f !== 32'h4 || valid_d !== 1'b1 || instr_d !== 32'hE000_0000 || stall_cnt !== 4'd0 || hz_err !== 1'b0) begin errors++; $display("FAIL rst_post: got pc=%h vd=%b i=%h sc=%0d hz=%b exp 4 1 e0000000 0 0", pc_f, valid_d, instr_d, stall_cnt, hz_err); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_branch();
    test_branch_stall();
    test_saturation();
    test_hz_err_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
